strip_sequencer: RTL and testbench
==================================

Name: strip_sequencer

Overview:
Frame-level controller that streams one frame of 24-bit pixel colours from a synchronous frame-buffer RAM into the single-pixel LED driver over its valid/ready handshake. It then issues the driver's latch/reset request to end the frame. It applies a global brightness scale per channel and supports one-shot or continuous refresh. It sits between the frame buffer (written by the host side) and the pixel driver.

Parameters:
NUM_PIXELS, 64, pixels per frame (1..2**ADDR_BITS)
ADDR_BITS, 6, frame-buffer address width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high block reset
start  input  1  one-cycle request to send a frame; ignored unless state is IDLE
continuous  input  1  when 1, a new frame begins automatically after each frame completes
brightness  input  8  global scale, sampled at frame start
fb_rd_en  output  1  frame-buffer read strobe
fb_addr  output  ADDR_BITS  frame-buffer read address
fb_rd_data  input  24  read data {G[23:16],R[15:8],B[7:0]}, valid exactly 1 cycle after fb_rd_en
drv_color  output  24  colour to the pixel driver
drv_reset  output  1  latch request to the driver; qualified by drv_valid
drv_valid  output  1  transfer request to the driver
drv_ready  input  1  driver accepts when high
busy  output  1  high in any state other than IDLE
frame_done  output  1  one-cycle pulse when the latch transfer completes

Behaviour:
- All outputs are registered. Reset values: fb_rd_en=0, fb_addr=0, drv_color=0, drv_reset=0, drv_valid=0, busy=0, frame_done=0. State=IDLE, pixel index=0.
- Transfer rule: a transfer occurs on a rising edge where drv_valid && drv_ready. While drv_valid=1, drv_color and drv_reset hold stable until the transfer. drv_valid never drops without a transfer, except on reset.
- States:
  - IDLE: if start, latch brightness into scale register, set idx=0, go to FETCH.
  - FETCH: fb_rd_en=1, fb_addr=idx, for exactly 1 cycle; go to LOAD.
  - LOAD: capture fb_rd_data, scale it, register into drv_color; go to SEND.
  - SEND: drv_valid=1, drv_reset=0. On transfer: if idx==NUM_PIXELS-1 go to LATCH, else idx+1 and go to FETCH.
  - LATCH: drv_valid=1, drv_reset=1, drv_color=0. On transfer go to DONE.
  - DONE: frame_done=1 for this cycle only. If continuous, re-sample brightness, set idx=0 and go to FETCH; else go to IDLE.
- Latency: with start sampled at edge 0, fb_rd_en is high in cycle 1 and drv_valid first rises in cycle 3. Each pixel costs 3 cycles plus ready stall cycles. A frame with ready always high takes 3*NUM_PIXELS+2 cycles from start to frame_done.
- Scaling: for each 8-bit channel c, out = (c*(brightness+1))>>8, using a 16-bit product truncated to 8 bits. brightness=255 gives identity; brightness=0 gives 0 for every c. A change to brightness mid-frame has no effect until the next frame start.
- idx counter is ADDR_BITS wide and never exceeds NUM_PIXELS-1; no wrap within a frame.
- start while busy=1 is ignored, with no queuing. Dropping continuous mid-frame lets the current frame finish, then the block goes to IDLE.
- reset asserted in any state: next edge returns to reset values. This includes an abandoned SEND or LATCH, in which case drv_valid falls without a transfer. frame_done is not pulsed.
- fb_rd_en is never high outside FETCH.

Test Plan:
- NUM_PIXELS=4, RAM={0x112233,0x445566,0x778899,0xAABBCC}, brightness=255, drv_ready=1, start pulse -> drv_color sequence 0x112233, 0x445566, 0x778899, 0xAABBCC, then one drv_reset=1 transfer. frame_done fires 14 cycles after start; busy falls the next cycle.
- Same frame, drv_ready held low 5 cycles on pixel 2 -> drv_valid and drv_color=0x778899 stay stable for all 6 cycles; output sequence unchanged.
- brightness=127, RAM[0]=0xFF8001 -> drv_color=0x7F4000; brightness=0 -> drv_color=0x000000. brightness changed to 255 mid-frame -> remaining pixels still use 127.
- continuous=1 -> back-to-back frames, fb_addr returns to 0 the cycle after each frame_done. Clear continuous during frame 2 -> frame 2 completes, then IDLE.
- start pulsed during SEND of pixel 1 -> ignored; exactly one frame sent.
- reset asserted while in LATCH with drv_ready=0 -> next cycle drv_valid=0, drv_reset=0, busy=0, no frame_done. A subsequent start sends a full frame from address 0.

Source files
------------

// File: rtl/strip_sequencer.sv
// strip_sequencer: streams one frame of 24-bit pixels from a synchronous frame
// buffer into a single-pixel LED driver over a valid/ready handshake. After the
// last pixel it sends one latch request. A brightness scale is applied to each
// channel. Refresh is one-shot or continuous.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   start             one-cycle frame request, honoured only when idle
//   continuous        restart automatically after each frame
//   brightness        global scale, sampled at each frame start
//   fb_rd_en/fb_addr  frame-buffer read strobe and address
//   fb_rd_data        read data {G,R,B}, valid one cycle after fb_rd_en
//   drv_color         pixel colour to the driver
//   drv_reset         latch request, qualified by drv_valid
//   drv_valid         transfer request to the driver
//   drv_ready         driver accepts when high
//   busy              high whenever not idle
//   frame_done        one-cycle pulse when the latch transfer completes
module strip_sequencer #(
    parameter int unsigned NUM_PIXELS = 64,
    parameter int unsigned ADDR_BITS  = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [7:0]           brightness,
    output logic                 fb_rd_en,
    output logic [ADDR_BITS-1:0] fb_addr,
    input  logic [23:0]          fb_rd_data,
    output logic [23:0]          drv_color,
    output logic                 drv_reset,
    output logic                 drv_valid,
    input  logic                 drv_ready,
    output logic                 busy,
    output logic                 frame_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StSend,
        StLatch,
        StDone
    } state_e;

    localparam logic [ADDR_BITS-1:0] LastIdx = ADDR_BITS'(NUM_PIXELS - 1);

    state_e                state_q, state_d;
    logic [ADDR_BITS-1:0]  idx_q, idx_d;
    logic [7:0]            scale_q, scale_d;
    logic                  fb_rd_en_q, fb_rd_en_d;
    logic [ADDR_BITS-1:0]  fb_addr_q, fb_addr_d;
    logic [23:0]           drv_color_q, drv_color_d;
    logic                  drv_reset_q, drv_reset_d;
    logic                  drv_valid_q, drv_valid_d;
    logic                  busy_q, busy_d;
    logic                  frame_done_q, frame_done_d;

    // out = (c * (scale + 1)) >> 8 in a 16-bit product; scale 255 is identity.
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] s);
        return 8'((16'(c) * 16'(s + 9'd1)) >> 8);
    endfunction

    function automatic logic [23:0] scale_pixel(input logic [23:0] px, input logic [7:0] s);
        return {scale_chan(px[23:16], s), scale_chan(px[15:8], s), scale_chan(px[7:0], s)};
    endfunction

    logic xfer;
    assign xfer = drv_valid_q && drv_ready;

    // Outputs are registered: each next-state branch also sets the output
    // values that belong to the state being entered.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        scale_d      = scale_q;
        fb_rd_en_d   = 1'b0;
        fb_addr_d    = fb_addr_q;
        drv_color_d  = drv_color_q;
        drv_reset_d  = drv_reset_q;
        drv_valid_d  = drv_valid_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (start) begin
                    scale_d    = brightness;
                    idx_d      = '0;
                    fb_addr_d  = '0;
                    fb_rd_en_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = StFetch;
                end
            end
            StFetch: begin
                state_d = StLoad;
            end
            StLoad: begin
                drv_color_d = scale_pixel(fb_rd_data, scale_q);
                drv_reset_d = 1'b0;
                drv_valid_d = 1'b1;
                state_d     = StSend;
            end
            StSend: begin
                if (xfer) begin
                    if (idx_q == LastIdx) begin
                        drv_color_d = '0;
                        drv_reset_d = 1'b1;
                        drv_valid_d = 1'b1;
                        state_d     = StLatch;
                    end else begin
                        drv_valid_d = 1'b0;
                        idx_d       = idx_q + 1'b1;
                        fb_addr_d   = idx_q + 1'b1;
                        fb_rd_en_d  = 1'b1;
                        state_d     = StFetch;
                    end
                end
            end
            StLatch: begin
                if (xfer) begin
                    drv_valid_d  = 1'b0;
                    drv_reset_d  = 1'b0;
                    frame_done_d = 1'b1;
                    state_d      = StDone;
                end
            end
            StDone: begin
                if (continuous) begin
                    scale_d    = brightness;
                    idx_d      = '0;
                    fb_addr_d  = '0;
                    fb_rd_en_d = 1'b1;
                    state_d    = StFetch;
                end else begin
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            scale_q      <= '0;
            fb_rd_en_q   <= 1'b0;
            fb_addr_q    <= '0;
            drv_color_q  <= '0;
            drv_reset_q  <= 1'b0;
            drv_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            scale_q      <= scale_d;
            fb_rd_en_q   <= fb_rd_en_d;
            fb_addr_q    <= fb_addr_d;
            drv_color_q  <= drv_color_d;
            drv_reset_q  <= drv_reset_d;
            drv_valid_q  <= drv_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign fb_rd_en   = fb_rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign drv_color  = drv_color_q;
    assign drv_reset  = drv_reset_q;
    assign drv_valid  = drv_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_strip_sequencer.sv
// Testbench for strip_sequencer with a 4-pixel frame. A frame-buffer model
// answers reads, a scoreboard holds the expected driver transfers, and a
// negedge monitor compares each transfer and checks that requests stay stable.
module tb_strip_sequencer;

    localparam int NPIX  = 4;
    localparam int ABITS = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             continuous;
    logic [7:0]       brightness;
    logic             fb_rd_en;
    logic [ABITS-1:0] fb_addr;
    logic [23:0]      fb_rd_data;
    logic [23:0]      drv_color;
    logic             drv_reset;
    logic             drv_valid;
    logic             drv_ready;
    logic             busy;
    logic             frame_done;

    strip_sequencer #(
        .NUM_PIXELS(NPIX),
        .ADDR_BITS (ABITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .continuous(continuous),
        .brightness(brightness),
        .fb_rd_en  (fb_rd_en),
        .fb_addr   (fb_addr),
        .fb_rd_data(fb_rd_data),
        .drv_color (drv_color),
        .drv_reset (drv_reset),
        .drv_valid (drv_valid),
        .drv_ready (drv_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    logic [23:0] ram [0:(1<<ABITS)-1];
    always @(posedge clk) if (fb_rd_en) fb_rd_data <= ram[fb_addr];

    typedef struct packed {
        logic [23:0] color;
        logic        rst;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [23:0] model_scale(input logic [23:0] px, input int b);
        int r = 0;
        for (int k = 0; k < 3; k++) begin
            int ch = int'((px >> (8 * k)) & 24'hFF);
            r = r | (((ch * (b + 1)) / 256) << (8 * k));
        end
        return 24'(r);
    endfunction

    task automatic push_frame(input int b);
        for (int i = 0; i < NPIX; i++) exp_q.push_back('{color: model_scale(ram[i], b), rst: 1'b0});
        exp_q.push_back('{color: 24'h0, rst: 1'b1});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns one cycle after start's sampling edge (cycle 1 of the frame).
    task automatic start_frame(input logic [7:0] b);
        brightness = b;
        push_frame(int'(b));
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int cyc0, output int cyc);
        cyc = cyc0;
        while (!frame_done && cyc < 400) begin
            step();
            cyc++;
        end
        check({tag, "_done_seen"}, frame_done, 1);
    endtask

    // Transfer monitor: sampled at negedge, inputs only change just after posedge.
    initial begin
        logic        pending = 1'b0;
        logic [23:0] held_color = '0;
        logic        held_rst = 1'b0;
        logic        prev_done = 1'b0;
        logic        prev_rd = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (reset) begin
                pending   = 1'b0;
                prev_done = 1'b0;
                prev_rd   = 1'b0;
            end else begin
                if (pending) begin
                    check("hold_valid", drv_valid, 1);
                    check("hold_color", drv_color, held_color);
                    check("hold_rst", drv_reset, held_rst);
                end
                if (drv_valid && drv_ready) begin
                    check("sb_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("xfer_color", drv_color, e.color);
                        check("xfer_rst", drv_reset, e.rst);
                    end
                end
                if (frame_done) begin
                    check("done_pulse", prev_done, 0);
                    done_cnt++;
                end
                if (fb_rd_en) check("rd_pulse", prev_rd, 0);
                pending    = drv_valid && !drv_ready;
                held_color = drv_color;
                held_rst   = drv_reset;
                prev_done  = frame_done;
                prev_rd    = fb_rd_en;
            end
        end
    end

    initial begin
        int cyc;
        int t;
        int d0;
        reset      = 1'b1;
        start      = 1'b0;
        continuous = 1'b0;
        brightness = 8'd255;
        drv_ready  = 1'b1;
        for (int i = 0; i < (1 << ABITS); i++) ram[i] = 24'h0;
        ram[0] = 24'h112233;
        ram[1] = 24'h445566;
        ram[2] = 24'h778899;
        ram[3] = 24'hAABBCC;
        repeat (3) step();
        reset = 1'b0;

        // Reset state
        check("rst_rd_en", fb_rd_en, 0);
        check("rst_addr", fb_addr, 0);
        check("rst_color", drv_color, 0);
        check("rst_drv_reset", drv_reset, 0);
        check("rst_valid", drv_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        step();

        // Basic frame with latency checks
        start_frame(8'd255);
        check("t1_rd_en_c1", fb_rd_en, 1);
        check("t1_addr_c1", fb_addr, 0);
        check("t1_busy_c1", busy, 1);
        step();
        check("t1_rd_en_c2", fb_rd_en, 0);
        check("t1_valid_c2", drv_valid, 0);
        step();
        check("t1_valid_c3", drv_valid, 1);
        check("t1_color_c3", drv_color, 24'h112233);
        wait_done("t1", 3, cyc);
        check("t1_done_cycle", cyc, 3 * NPIX + 2);
        step();
        check("t1_busy_after", busy, 0);
        check("t1_done_after", frame_done, 0);
        check("t1_sb_empty", exp_q.size(), 0);
        step();

        // Ready stall on pixel 2
        start_frame(8'd255);
        t = 0;
        while (!(fb_rd_en && fb_addr == 6'd2) && t < 100) begin step(); t++; end
        check("t2_fetch2_seen", fb_rd_en && fb_addr == 6'd2, 1);
        drv_ready = 1'b0;
        t = 0;
        while (!drv_valid && t < 10) begin step(); t++; end
        check("t2_valid0", drv_valid, 1);
        check("t2_color0", drv_color, 24'h778899);
        for (int i = 0; i < 5; i++) begin
            step();
            check("t2_stall_valid", drv_valid, 1);
            check("t2_stall_color", drv_color, 24'h778899);
        end
        drv_ready = 1'b1;
        wait_done("t2", 0, cyc);
        step();
        check("t2_sb_empty", exp_q.size(), 0);

        // Scaling with mid-frame brightness change
        ram[0] = 24'hFF8001;
        start_frame(8'd127);
        brightness = 8'd255;
        step();
        step();
        check("t3_valid", drv_valid, 1);
        check("t3_color", drv_color, 24'h7F4000);
        wait_done("t3", 3, cyc);
        step();
        check("t3_sb_empty", exp_q.size(), 0);

        start_frame(8'd0);
        step();
        step();
        check("t4_color_zero", drv_color, 24'h000000);
        wait_done("t4", 3, cyc);
        step();
        check("t4_sb_empty", exp_q.size(), 0);

        // Continuous refresh, dropped during frame 2
        continuous = 1'b1;
        start_frame(8'd255);
        push_frame(255);
        wait_done("t5a", 1, cyc);
        check("t5a_done_cycle", cyc, 3 * NPIX + 2);
        step();
        check("t5_restart_rd", fb_rd_en, 1);
        check("t5_restart_addr", fb_addr, 0);
        check("t5_restart_busy", busy, 1);
        continuous = 1'b0;
        wait_done("t5b", 1, cyc);
        check("t5b_done_cycle", cyc, 3 * NPIX + 2);
        step();
        check("t5_busy_after", busy, 0);
        repeat (10) step();
        check("t5_idle_busy", busy, 0);
        check("t5_sb_empty", exp_q.size(), 0);

        // Start during SEND of pixel 1 is ignored
        d0 = done_cnt;
        start_frame(8'd255);
        t = 0;
        while (!(drv_valid && fb_addr == 6'd1) && t < 100) begin step(); t++; end
        check("t6_send1_seen", drv_valid && fb_addr == 6'd1, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done("t6", 0, cyc);
        repeat (20) step();
        check("t6_busy", busy, 0);
        check("t6_done_count", done_cnt - d0, 1);
        check("t6_sb_empty", exp_q.size(), 0);

        // Reset while stalled in LATCH
        start_frame(8'd255);
        t = 0;
        while (!(drv_valid && drv_reset) && t < 100) begin step(); t++; end
        check("t7_latch_seen", drv_valid && drv_reset, 1);
        drv_ready = 1'b0;
        step();
        step();
        d0 = done_cnt;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("t7_valid", drv_valid, 0);
        check("t7_drv_reset", drv_reset, 0);
        check("t7_busy", busy, 0);
        check("t7_done", frame_done, 0);
        repeat (4) step();
        check("t7_no_done", done_cnt - d0, 0);
        check("t7_pending_latch", exp_q.size(), 1);
        exp_q.delete();
        drv_ready = 1'b1;
        start_frame(8'd255);
        check("t7_restart_rd", fb_rd_en, 1);
        check("t7_restart_addr", fb_addr, 0);
        wait_done("t7", 1, cyc);
        check("t7_done_cycle", cyc, 3 * NPIX + 2);
        step();
        check("t7_sb_empty", exp_q.size(), 0);

        repeat (3) step();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
